// File: rtl/rr_reg_write_arbiter.sv
// Round-robin arbiter that sequences single-word writes from NREQ requesters
// into a small internal register bank using a 4-phase req/gnt handshake.
module rr_reg_write_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8,
    parameter int unsigned AW   = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] wr_addr,
    input  logic [NREQ*DW-1:0] wr_data,
    output logic [NREQ-1:0]    gnt,
    output logic               busy,
    input  logic [AW-1:0]      rd_addr,
    output logic [DW-1:0]      rd_data,
    output logic [7:0]         wr_count
);

    localparam int unsigned PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [DW-1:0]   bank [DEPTH];

    logic [PW-1:0]   win_c;
    logic [PW-1:0]   idx_c;
    logic            any_c;
    logic [AW-1:0]   sel_addr_c;
    logic [DW-1:0]   sel_data_c;

    // Circular first-set search starting at the priority pointer.
    always_comb begin
        win_c = '0;
        idx_c = '0;
        any_c = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx_c = PW'((32'(ptr) + k) % NREQ);
            if (!any_c && req[idx_c]) begin
                any_c = 1'b1;
                win_c = idx_c;
            end
        end
    end

    assign sel_addr_c = wr_addr[32'(win_c)*AW +: AW];
    assign sel_data_c = wr_data[32'(win_c)*DW +: DW];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            gnt      <= '0;
            ptr      <= '0;
            owner    <= '0;
            wr_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (any_c) begin
                        bank[sel_addr_c] <= sel_data_c;
                        gnt              <= NREQ'(1) << win_c;
                        owner            <= win_c;
                        wr_count         <= wr_count + 8'd1;
                        state            <= GRANT;
                    end
                end
                GRANT: begin
                    gnt   <= '0;
                    state <= RELEASE;
                end
                RELEASE: begin
                    // Served requester drops to lowest priority once it lets go.
                    if (!req[owner]) begin
                        state <= IDLE;
                        ptr   <= (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
                    end
                end
                default: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign rd_data = bank[rd_addr];

endmodule

// File: tb/tb_rr_reg_write_arbiter.sv
// Bench for rr_reg_write_arbiter: directed scenarios plus randomized masters,
// checked every cycle against a transaction-level reference model.
module tb_rr_reg_write_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] wr_addr;
    logic [NREQ*DW-1:0] wr_data;
    logic [NREQ-1:0]    gnt;
    logic               busy;
    logic [AW-1:0]      rd_addr;
    logic [DW-1:0]      rd_data;
    logic [7:0]         wr_count;

    rr_reg_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .gnt      (gnt),
        .busy     (busy),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: one outstanding transaction (holder), a fairness pointer,
    // the bank contents and the write counter.
    bit         m_valid = 1'b0;
    int         m_holder;        // -1: idle
    bit         m_in_grant;      // holder is in its single gnt cycle
    int         m_ptr;
    int         m_count;
    logic [7:0] m_bank [DEPTH];

    function automatic int pick_winner();
        for (int k = 0; k < NREQ; k++) begin
            int c;
            c = (m_ptr + k) % NREQ;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int w;
        if (!reset_n) begin
            m_valid    = 1'b1;
            m_holder   = -1;
            m_in_grant = 1'b0;
            m_ptr      = 0;
            m_count    = 0;
            for (int i = 0; i < DEPTH; i++) m_bank[i] = 8'h00;
        end else if (m_valid) begin
            if (m_holder < 0) begin
                w = pick_winner();
                if (w >= 0) begin
                    m_bank[wr_addr[w*AW +: AW]] = wr_data[w*DW +: DW];
                    m_count    = (m_count + 1) % 256;
                    m_holder   = w;
                    m_in_grant = 1'b1;
                end
            end else if (m_in_grant) begin
                m_in_grant = 1'b0;
            end else if (!req[m_holder]) begin
                m_ptr    = (m_holder + 1) % NREQ;
                m_holder = -1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_edge();
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check_eq("gnt",      32'(gnt),      (m_holder >= 0 && m_in_grant) ? (32'd1 << m_holder) : 32'd0);
            check_eq("busy",     32'(busy),     32'(m_holder >= 0));
            check_eq("wr_count", 32'(wr_count), 32'(m_count));
            check_eq("rd_data",  32'(rd_data),  32'(m_bank[rd_addr]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_addr[i*AW +: AW] = a;
        wr_data[i*DW +: DW] = d;
    endtask

    int         order [5];
    int         n_got;
    int         idx;
    bit         granted [NREQ];
    int         hold    [NREQ];

    initial begin
        reset_n = 1'b0;
        req     = 4'b1111;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;

        // Reset with all requests pending.
        tick();
        tick();
        check_eq("rst_gnt", 32'(gnt), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_count", 32'(wr_count), 32'd0);
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = AW'(a);
            #1;
            check_eq("rst_rd", 32'(rd_data), 32'd0);
        end
        reset_n = 1'b1;
        tick();
        check_eq("rst_first_gnt", 32'(gnt), 32'b0001);
        req = '0;
        tick(); tick(); tick();

        // Single write from requester 2.
        do_reset();
        set_wr(2, 2'd3, 8'hA5);
        req     = 4'b0100;
        rd_addr = 2'd3;
        tick();
        check_eq("sw_gnt", 32'(gnt), 32'b0100);
        check_eq("sw_busy", 32'(busy), 32'd1);
        check_eq("sw_rd", 32'(rd_data), 32'hA5);
        check_eq("sw_count", 32'(wr_count), 32'd1);
        for (int a = 0; a < 3; a++) begin
            rd_addr = AW'(a);
            #1;
            check_eq("sw_other", 32'(rd_data), 32'd0);
        end
        tick();
        check_eq("sw_rel_gnt", 32'(gnt), 32'd0);
        check_eq("sw_rel_busy", 32'(busy), 32'd1);
        req[2] = 1'b0;
        tick();
        check_eq("sw_idle_busy", 32'(busy), 32'd0);

        // Round-robin with all requests held.
        do_reset();
        req   = 4'b1111;
        n_got = 0;
        for (int cyc = 0; cyc < 80 && n_got < 5; cyc++) begin
            tick();
            if (gnt != '0) begin
                idx = 0;
                for (int j = 0; j < NREQ; j++) if (gnt[j]) idx = j;
                order[n_got] = idx;
                n_got++;
                tick();
                req[idx] = 1'b0;
                tick();
                req[idx] = 1'b1;
            end
        end
        check_eq("rr_n_grants", 32'(n_got), 32'd5);
        for (int k = 0; k < 5; k++) check_eq("rr_order", 32'(order[k]), 32'(k % NREQ));
        req = '0;
        tick(); tick(); tick(); tick();

        // Requester 1 holds its req while requester 3 waits.
        do_reset();
        set_wr(1, 2'd1, 8'h5A);
        set_wr(3, 2'd2, 8'hC3);
        rd_addr = 2'd2;
        req     = 4'b1010;
        tick();
        check_eq("hs_gnt1", 32'(gnt), 32'b0010);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("hs_hold_gnt", 32'(gnt), 32'd0);
            check_eq("hs_hold_bank", 32'(rd_data), 32'd0);
        end
        req[1] = 1'b0;
        tick();
        check_eq("hs_idle_gnt", 32'(gnt), 32'd0);
        tick();
        check_eq("hs_gnt3", 32'(gnt), 32'b1000);
        check_eq("hs_bank", 32'(rd_data), 32'hC3);
        tick();
        req[3] = 1'b0;
        tick(); tick();

        // Write data captured only at the arbitration edge.
        do_reset();
        set_wr(0, 2'd1, 8'h11);
        rd_addr = 2'd1;
        req     = 4'b0001;
        tick();
        wr_data[0 +: DW] = 8'h22;
        tick();
        tick();
        check_eq("cap_bank", 32'(rd_data), 32'h11);
        req = '0;
        tick(); tick();

        // Reset during RELEASE clears bank and pointer.
        do_reset();
        set_wr(2, 2'd0, 8'hFF);
        set_wr(3, 2'd1, 8'h77);
        rd_addr = 2'd0;
        req     = 4'b0100;
        tick();
        tick();
        check_eq("mr_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        tick();
        check_eq("mr_rst_busy", 32'(busy), 32'd0);
        check_eq("mr_rst_count", 32'(wr_count), 32'd0);
        check_eq("mr_rst_bank", 32'(rd_data), 32'd0);
        req     = 4'b1100;
        reset_n = 1'b1;
        tick();
        check_eq("mr_ptr_gnt", 32'(gnt), 32'b0100);
        req = '0;
        tick(); tick(); tick();

        // wr_count wraps after 256 writes.
        do_reset();
        for (int n = 0; n < 256; n++) begin
            set_wr(0, AW'(n), DW'(n));
            req = 4'b0001;
            tick();
            req = '0;
            tick();
            tick();
            if (n == 254) check_eq("wrap_255", 32'(wr_count), 32'd255);
        end
        check_eq("wrap_zero", 32'(wr_count), 32'd0);

        // Randomized masters, occasional withdraw and reset.
        for (int i = 0; i < NREQ; i++) begin
            granted[i] = 1'b0;
            hold[i]    = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            reset_n = ($urandom_range(0, 299) != 0);
            rd_addr = AW'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i]) begin
                    granted[i] = 1'b1;
                    hold[i]    = $urandom_range(0, 3);
                end else if (granted[i]) begin
                    if ($urandom_range(0, 1) == 0) wr_data[i*DW +: DW] = DW'($urandom);
                    if (hold[i] == 0) begin
                        req[i]     = 1'b0;
                        granted[i] = 1'b0;
                    end else begin
                        hold[i]--;
                    end
                end else if (req[i]) begin
                    if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    set_wr(i, AW'($urandom), DW'($urandom));
                end
            end
        end
        reset_n = 1'b1;
        req     = '0;
        tick(); tick(); tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_reg_write_arbiter.md
Name: rr_reg_write_arbiter

Overview:
- Round-robin arbiter and sequencer for a small bank of enabled D registers (2^AW words x DW bits).
- NREQ requesters share a single write path into the bank.
- The block grants one requester at a time, generates the per-word write enable, and enforces a 4-phase req/gnt handshake.
- It sits between control-path masters and the shared register bank. The bank is internal, with one combinational read port.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, data width of each bank word.
- AW, 2, address width. Bank depth is 2^AW.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset. Sampled only on posedge clk.
- req  in  NREQ  request per requester. Held high until its gnt has pulsed.
- wr_addr  in  NREQ*AW  packed word addresses. Requester i occupies bits [i*AW +: AW].
- wr_data  in  NREQ*DW  packed write data. Requester i occupies bits [i*DW +: DW].
- gnt  out  NREQ  registered one-hot grant. High for exactly one cycle per accepted write.
- busy  out  1  high whenever the state is not IDLE.
- rd_addr  in  AW  read address.
- rd_data  out  DW  combinational read: rd_data = bank[rd_addr].
- wr_count  out  8  count of completed writes. Wraps 255 -> 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on reset_n.
  - reset_n low at a posedge: state=IDLE, gnt=0, busy=0, priority pointer=0, wr_count=0, every bank word=0.
  - A reset in the middle of an operation aborts it immediately. gnt drops at that edge, and no write is performed at that edge.
- States: IDLE, GRANT, RELEASE.
- IDLE, arbitration:
  - At a posedge with any req bit set, the winner is the first set bit found searching circularly from the priority pointer, i.e. ptr, ptr+1, ..., ptr+NREQ-1 mod NREQ.
  - At that same edge:
    - bank[wr_addr[w]] <= wr_data[w]. Only the addressed word is enabled; all other words hold.
    - gnt <= onehot(w).
    - wr_count <= wr_count+1.
    - state <= GRANT.
- GRANT:
  - Lasts exactly one cycle, with gnt=onehot(w). rd_data already reflects the new word in this cycle.
  - At the next edge, gnt <= 0 and state <= RELEASE.
- RELEASE:
  - Stay while req[w]==1.
  - At the first edge where req[w]==0, move to IDLE and set ptr <= (w+1) mod NREQ.
  - No arbitration occurs in that edge. The minimum gap between two grants is 3 cycles.
- Latency: req sampled high at edge k gives gnt high in cycle k..k+1, with the data written at edge k.
- Input capture:
  - wr_addr and wr_data are sampled only at the arbitration edge. Later changes are ignored.
  - A req that drops before the arbitration edge is never granted and causes no write.
- Other requesters: bits of req other than w have no effect during GRANT and RELEASE. They stay pending and compete at the next IDLE edge.
- Fairness: the requester just served becomes lowest priority. With all NREQ requests held continuously, the grant order is 0,1,2,3,0,...
- Write collisions: only one write is possible per arbitration, so there are no write collisions. A read of the same address in the write cycle returns the old value until the edge, then the new value.
- busy: combinational from state, high in GRANT and RELEASE.

Test Plan:
- Reset: hold reset_n=0 for 2 edges with req=4'b1111 -> gnt=0, busy=0, wr_count=0, rd_data=0 for all rd_addr. Releasing reset grants requester 0 first.
- Single write: req[2]=1, wr_addr[2]=3, wr_data[2]=8'hA5.
  - gnt=4'b0100 for one cycle, busy=1.
  - rd_addr=3 -> rd_data=8'hA5 in the gnt cycle. Other words remain 0, and wr_count=1.
  - Drop req[2] -> IDLE one edge later, busy=0.
- Round-robin: req=4'b1111 held. Each granted requester drops its req for one cycle after gnt, then reasserts -> grant order 0,1,2,3,0. No requester is granted twice before all the others.
- Handshake hold: req[1] stays high 5 cycles after gnt while req[3]=1 -> no gnt during those cycles. gnt=4'b1000 is issued only after req[1] falls, and the bank changes only at that grant.
- Data capture: change wr_data[0] from 8'h11 to 8'h22 one cycle after requester 0's arbitration edge -> bank holds 8'h11.
- Mid-operation reset and wrap:
  - Assert reset_n=0 during RELEASE -> state IDLE, bank cleared, ptr=0.
  - Separately, after 256 writes -> wr_count=0.
